// File: rtl/score4_move_seq.sv
// Automated Connect-Four move sequencer: walks an internal cursor model to a requested
// column with left/right pulses, then drops the token with a put pulse.
module score4_move_seq #(
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned GAP_LEN   = 4,
  parameter int unsigned NUM_COLS  = 7,
  parameter int unsigned START_COL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] target_col,
  input  logic       new_game,
  output logic       left,
  output logic       right,
  output logic       put,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] cur_col
);

  localparam int unsigned MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [2:0]       START      = 3'(START_COL);
  localparam logic [3:0]       COLS       = 4'(NUM_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_STEP_HI,
    S_STEP_GAP,
    S_PUT_HI,
    S_PUT_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [2:0]       cur_q, cur_d;
  logic             dir_right_q, dir_right_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic             put_q, put_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next-state and registered-output logic; outputs follow the state one edge later.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    cur_d       = cur_q;
    dir_right_d = dir_right_q;
    left_d      = 1'b0;
    right_d     = 1'b0;
    put_d       = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (new_game) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cur_d   = START;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            if ({1'b0, target_col} < COLS) begin
              tgt_d   = target_col;
              state_d = S_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          busy_d = 1'b1;
          cnt_d  = '0;
          if (tgt_q != cur_q) begin
            dir_right_d = (tgt_q > cur_q);
            state_d     = S_STEP_HI;
          end else begin
            state_d = S_PUT_HI;
          end
        end
        S_STEP_HI: begin
          busy_d  = 1'b1;
          right_d = dir_right_q;
          left_d  = ~dir_right_q;
          if (cnt_q == PULSE_LAST) begin
            cnt_d   = '0;
            cur_d   = dir_right_q ? (cur_q + 3'd1) : (cur_q - 3'd1);
            state_d = S_STEP_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STEP_GAP: begin
          busy_d = 1'b1;
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = (cur_q == tgt_q) ? S_PUT_HI : S_STEP_HI;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PUT_HI: begin
          busy_d = 1'b1;
          put_d  = 1'b1;
          if (cnt_q == PULSE_LAST) begin
            cnt_d   = '0;
            state_d = S_PUT_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PUT_GAP: begin
          busy_d = 1'b1;
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      cur_q       <= START;
      dir_right_q <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      put_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
      dir_right_q <= dir_right_d;
      left_q      <= left_d;
      right_q     <= right_d;
      put_q       <= put_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign left    = left_q;
  assign right   = right_q;
  assign put     = put_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cur_col = cur_q;

endmodule

// File: tb/tb_score4_move_seq.sv
// Self-checking bench for score4_move_seq: per-cycle output waveforms compared against
// a timing model derived from move distance and direction.
module tb_score4_move_seq;

  localparam int P   = 2;
  localparam int G   = 4;
  localparam int NC  = 7;
  localparam int SC  = 3;
  localparam int PER = P + G;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] target_col;
  logic       new_game;
  logic       left, right, put, busy, done, err;
  logic [2:0] cur_col;

  int checks = 0;
  int errors = 0;
  int model_cur = SC;

  always #5 clk = ~clk;

  score4_move_seq #(
    .PULSE_LEN(P), .GAP_LEN(G), .NUM_COLS(NC), .START_COL(SC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .target_col(target_col), .new_game(new_game),
    .left(left), .right(right), .put(put), .busy(busy), .done(done), .err(err),
    .cur_col(cur_col)
  );

  // Expected {left,right,put,busy,done,err} for the cycle starting at edge t0+n.
  function automatic logic [5:0] expect_at(input int n, input int d, input bit dir_right);
    int done_n;
    int rel;
    int k;
    logic l, r, p, b, dn;
    l = 1'b0; r = 1'b0; p = 1'b0;
    done_n = 2 + (d + 1) * PER;
    if (n >= 2 && n < done_n) begin
      rel = n - 2;
      k   = rel / PER;
      if ((rel % PER) < P) begin
        if (k < d) begin
          if (dir_right) r = 1'b1;
          else           l = 1'b1;
        end else begin
          p = 1'b1;
        end
      end
    end
    b  = (n >= 1) && (n < done_n);
    dn = (n == done_n);
    return {l, r, p, b, dn, 1'b0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one move; optionally raise a stray req after cycle inject_n, or abort after cycle abort_n.
  task automatic run_move(input int tgt, input int inject_n, input int abort_n, input bit abort_rst);
    int d;
    bit dr;
    int done_n;
    logic [5:0] obs, expv;
    d      = (tgt > model_cur) ? tgt - model_cur : model_cur - tgt;
    dr     = (tgt > model_cur);
    done_n = 2 + (d + 1) * PER;
    req = 1'b1;
    target_col = 3'(tgt);
    tick;
    req = 1'b0;
    for (int n = 0; n <= done_n + 1; n++) begin
      obs  = {left, right, put, busy, done, err};
      expv = expect_at(n, d, dr);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL move_wave tgt=%0d n=%0d got=%b exp=%b", tgt, n, obs, expv);
      end
      if (n == abort_n) begin
        if (abort_rst) rst = 1'b1;
        else           new_game = 1'b1;
        tick;
        rst = 1'b0;
        new_game = 1'b0;
        model_cur = SC;
        checks++;
        if ({left, right, put, busy, done, err} !== 6'b0 || cur_col !== 3'(SC)) begin
          errors++;
          $display("FAIL abort_next got=%b cur=%0d exp=000000 cur=%0d",
                   {left, right, put, busy, done, err}, cur_col, SC);
        end
        for (int i = 0; i < 8; i++) begin
          tick;
          checks++;
          if ({left, right, put, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL abort_quiet i=%0d got=%b exp=000000", i, {left, right, put, busy, done, err});
          end
        end
        return;
      end
      req = (n == inject_n);
      if (req) target_col = 3'($urandom_range(0, NC - 1));
      tick;
    end
    req = 1'b0;
    checks++;
    if (cur_col !== 3'(tgt)) begin
      errors++;
      $display("FAIL move_cur tgt=%0d got=%0d exp=%0d", tgt, cur_col, tgt);
    end
    model_cur = tgt;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; new_game = 1'b0; target_col = 3'd0;
    repeat (3) tick;
    checks++;
    if ({left, right, put, busy, done, err} !== 6'b0 || cur_col !== 3'(SC)) begin
      errors++;
      $display("FAIL reset_hold got=%b cur=%0d exp=000000 cur=%0d",
               {left, right, put, busy, done, err}, cur_col, SC);
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({left, right, put, busy, done, err} !== 6'b0 || cur_col !== 3'(SC)) begin
      errors++;
      $display("FAIL reset_release got=%b cur=%0d exp=000000 cur=%0d",
               {left, right, put, busy, done, err}, cur_col, SC);
    end
    model_cur = SC;
  endtask

  task automatic test_invalid;
    req = 1'b1;
    target_col = 3'd7;
    tick;
    req = 1'b0;
    checks++;
    if ({left, right, put, busy, done, err} !== 6'b000001) begin
      errors++;
      $display("FAIL invalid_err got=%b exp=000001", {left, right, put, busy, done, err});
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if ({left, right, put, busy, done, err} !== 6'b0 || cur_col !== 3'(model_cur)) begin
        errors++;
        $display("FAIL invalid_after i=%0d got=%b cur=%0d exp=000000 cur=%0d",
                 i, {left, right, put, busy, done, err}, cur_col, model_cur);
      end
    end
  endtask

  task automatic test_newgame_with_req;
    new_game = 1'b1;
    req = 1'b1;
    target_col = 3'd6;
    tick;
    new_game = 1'b0;
    req = 1'b0;
    model_cur = SC;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({left, right, put, busy, done, err} !== 6'b0 || cur_col !== 3'(SC)) begin
        errors++;
        $display("FAIL newgame_req i=%0d got=%b cur=%0d exp=000000 cur=%0d",
                 i, {left, right, put, busy, done, err}, cur_col, SC);
      end
      tick;
    end
  endtask

  task automatic test_random;
    int tgt;
    int d;
    for (int m = 0; m < 20; m++) begin
      if ($urandom_range(0, 7) == 0) begin
        test_invalid;
      end else begin
        tgt = $urandom_range(0, NC - 1);
        d = (tgt > model_cur) ? tgt - model_cur : model_cur - tgt;
        if ($urandom_range(0, 1) == 1)
          run_move(tgt, $urandom_range(0, 1 + (d + 1) * PER), -1, 1'b0);
        else
          run_move(tgt, -1, -1, 1'b0);
      end
    end
  endtask

  initial begin
    test_reset;
    run_move(3, -1, -1, 1'b0);                 // zero distance
    run_move(6, -1, -1, 1'b0);                 // three steps right
    run_move(0, -1, -1, 1'b0);                 // six steps left
    test_invalid;
    run_move(5, -1, 2 + 5 * PER, 1'b0);        // new_game during PUT_HI
    test_newgame_with_req;
    run_move(1, P + 2, -1, 1'b0);              // stray req during STEP_GAP
    run_move(6, -1, 7, 1'b1);                  // reset mid-move
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score4_move_seq.md
# score4_move_seq

Automated move sequencer for the Connect-Four game core. It sits on the game's button-input side and drives the same `left`/`right`/`put` lines a human player would, so the game's rising-edge detectors see clean pulses. It accepts one column request at a time, tracks the cursor column internally, and emits the shortest run of `left` or `right` pulses followed by one `put` pulse. It then reports completion, so a CPU opponent or a test driver can play through the normal input path.

## Interface
- `PULSE_LEN`, default 2: cycles each output pulse stays high; legal range ≥1.
- `GAP_LEN`, default 4: low cycles after each pulse; legal range ≥2, so the game sees a low-to-high edge on every pulse.
- `NUM_COLS`, default 7: number of board columns.
- `START_COL`, default 3: cursor column after reset or `new_game`.

Ports (name, direction, width, meaning):
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `req` input 1: start a move; sampled only in IDLE.
- `target_col` input 3: column to drop into, 0..`NUM_COLS`-1; sampled with `req`.
- `new_game` input 1: abort any move and return the cursor model to `START_COL`.
- `left` output 1: move-left pulse to the game core.
- `right` output 1: move-right pulse to the game core.
- `put` output 1: drop-token pulse to the game core.
- `busy` output 1: a move is in progress.
- `done` output 1: one-cycle pulse when a move completes.
- `err` output 1: one-cycle pulse when a request is rejected.
- `cur_col` output 3: internal cursor model.

## Operation
- **Reset values.** All outputs are registered. While `rst` is high:
  - `left`, `right`, `put`, `busy`, `done` and `err` are 0.
  - `cur_col` is `START_COL`.
  - State is IDLE.
- **States.** IDLE, CHECK, STEP_HI, STEP_GAP, PUT_HI, PUT_GAP, DONE.
- **IDLE.**
  - If `req`=1 and `target_col` < `NUM_COLS`: latch `target_col`, go to CHECK, set `busy`=1.
  - If `req`=1 and `target_col` ≥ `NUM_COLS`: pulse `err`=1 for one cycle, stay in IDLE, emit no move pulses.
- **CHECK.** Compares the latched target with `cur_col`.
  - Target ≠ `cur_col`: go to STEP_HI, with direction right if target > `cur_col`, otherwise left.
  - Target = `cur_col`: go to PUT_HI.
- **STEP_HI.** Drives the selected direction line high for `PULSE_LEN` cycles. On the last high cycle, `cur_col` increments (right) or decrements (left). Then go to STEP_GAP.
- **STEP_GAP.** All pulse lines low for `GAP_LEN` cycles. Then:
  - `cur_col` ≠ target: go to STEP_HI.
  - `cur_col` = target: go to PUT_HI.
- **PUT_HI.** `put` high for `PULSE_LEN` cycles, then PUT_GAP.
- **PUT_GAP.** All pulse lines low for `GAP_LEN` cycles, then DONE.
- **DONE.** `done`=1 and `busy`=0 for exactly one cycle, then IDLE. `cur_col` is unchanged by `put`.
- **Pulse exclusivity.** At most one of `left`/`right`/`put` is high in any cycle.
- **Cursor range.** `cur_col` never leaves 0..`NUM_COLS`-1, so no wrap-around pulse is ever issued.
- **Width rules.**
  - Distance = |target − `cur_col`|, range 0..`NUM_COLS`-1, 3 bits.
  - The single shared pulse/gap counter is sized to max(`PULSE_LEN`, `GAP_LEN`).
- **Requests while busy.** `req` in any state other than IDLE is ignored; there is no queueing and no `err`.
- **`new_game`.** Has priority over `req` in every state, including IDLE. Next cycle:
  - State is IDLE and `cur_col` = `START_COL`.
  - All pulse lines are 0 and `busy` is 0.
  - No `done` is issued.
- **Reset mid-move.** Same effect as `new_game`; a pulse may be cut short.

## Timing
- Accept edge t0 is the edge where IDLE samples `req`=1.
  - CHECK occupies the cycle after t0.
  - The first pulse is high starting at edge t0+2.
- Pulse timing for distance d:
  - Pulse k (k = 0..d; the last one is `put`) rises at t0+2+k·(`PULSE_LEN`+`GAP_LEN`).
  - `done` is high for the cycle starting at t0+2+(d+1)·(`PULSE_LEN`+`GAP_LEN`).
- `busy` is high from t0+1 up to, but not including, the `done` cycle.
- The next `req` can be accepted at the edge after `done`.
- `err` is high for the cycle after the rejecting edge; `busy` stays 0.

## Test plan
- **Zero-distance move.** Reset, then `req` with `target_col`=3 at t0 (P=2, G=4) → no `left`/`right`; `put` high t0+2..t0+3; `done` at t0+8; `cur_col`=3.
- **Move right.** `target_col`=6 from `cur_col`=3 → three `right` pulses at t0+2, +8, +14; `put` at t0+20; `done` at t0+26; `cur_col`=6.
- **Move left.** Then `target_col`=0 → six `left` pulses spaced 6 cycles apart; `put` at t0+38; `done` at t0+44; `cur_col`=0.
- **Invalid target.** `req` with `target_col`=7 → `err` for one cycle; no pulses; `busy`=0; `cur_col` unchanged.
- **Request while busy.** `req` asserted during STEP_GAP → ignored; the original move completes with unchanged timing and one `done`.
- **Abort.** `new_game` during PUT_HI of a move to column 5 → next cycle `put`=0, `busy`=0, `cur_col`=3, no `done`. `new_game` and `req` together in IDLE → request dropped.
